// File: rtl/hazard_if.sv
// hazard_if: decode instruction, PC select and hazard control/bypass outputs
interface hazard_if;
  logic [31:0] instr_i;
  logic [1:0]  pc_sel_i;
  logic        stallF_o;
  logic        stallD_o;
  logic        flushD_o;
  logic        flushE_o;
  logic [1:0]  bypA_sel_o;
  logic [1:0]  bypB_sel_o;
  modport master (
    output instr_i, pc_sel_i,
    input  stallF_o, stallD_o, flushD_o, flushE_o, bypA_sel_o, bypB_sel_o
  );
  modport slave (
    input  instr_i, pc_sel_i,
    output stallF_o, stallD_o, flushD_o, flushE_o, bypA_sel_o, bypB_sel_o
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: load-use/jump/branch stall-flush control and EX operand bypass selection
module hazard_unit #(
  parameter int N = 10
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);
  typedef enum logic [1:0] {IDLE, LD1, LD2, JMP} state_t;
  localparam int unused_n = N;
  state_t     state_q, state_d;
  logic [4:0] d1_q, d1_d, d2_q, d2_d;
  logic       d1v_q, d1v_d, d2v_q, d2v_d;
  logic [1:0] ty;
  logic [2:0] op;
  logic [4:0] ra, rb, rc;
  logic       writer, is_load, is_jmp, branch, flush_d;
  logic [11:0] unused_bits;
  assign unused_bits = hz.instr_i[26:15];
  assign ty = hz.instr_i[31:30];
  assign op = hz.instr_i[29:27];
  assign rc = hz.instr_i[14:10];
  assign rb = hz.instr_i[9:5];
  assign ra = hz.instr_i[4:0];
  assign writer = ty[1] | (ty == 2'b00 & (op == 3'b000 | op == 3'b001 | op == 3'b100))
                | (ty == 2'b01 & (op == 3'b101 | op == 3'b110));
  assign is_load = ty == 2'b00 & op == 3'b000;
  assign is_jmp = ty == 2'b01 & (op == 3'b000 | op >= 3'b101);
  assign branch = hz.pc_sel_i == 2'b01;
  assign flush_d = state_q != IDLE | branch;
  assign hz.stallF_o = state_q == LD1 | state_q == LD2;
  assign hz.stallD_o = state_q != IDLE;
  assign hz.flushD_o = flush_d;
  assign hz.flushE_o = state_q == LD2 | branch;
  assign hz.bypA_sel_o = rb == 5'd0 ? 2'b00 : (d1v_q & rb == d1_q) ? 2'b01 : (d2v_q & rb == d2_q) ? 2'b10 : 2'b00;
  assign hz.bypB_sel_o = rc == 5'd0 ? 2'b00 : (d1v_q & rc == d1_q) ? 2'b01 : (d2v_q & rc == d2_q) ? 2'b10 : 2'b00;
  // detection only in IDLE so a running load or jump sequence never retriggers
  always_comb begin
    state_d = IDLE;
    state_d = state_q == IDLE ? (!flush_d & is_load ? LD1 : !flush_d & is_jmp ? JMP : IDLE)
            : state_q == LD1 ? LD2 : IDLE;
    d1_d  = ra;
    d1v_d = writer & state_q == IDLE & !flush_d;
    d2_d  = d1_q;
    d2v_d = d1v_q & !branch;
  end
  // state and destination history registers; bubbles clear the younger slot
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      d1_q    <= 5'd0;
      d2_q    <= 5'd0;
      d1v_q   <= 1'b0;
      d2v_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d1v_q   <= d1v_d;
      d2v_q   <= d2v_d;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of stall/flush sequencing and bypass selection
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  hazard_if hz();
  hazard_unit #(.N(10)) dut (.clk(clk), .rst(rst), .hz(hz.slave));
  always #5 clk = ~clk;
  logic [3:0] ctl;
  assign ctl = {hz.stallF_o, hz.stallD_o, hz.flushD_o, hz.flushE_o};
  localparam logic [31:0] NOP = {2'b00, 3'b010, 27'd0};
  function automatic logic [31:0] mk(input logic [1:0] t, input logic [2:0] o,
                                     input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {t, o, 12'd0, c, b, a};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] ins, input logic [1:0] ps);
    hz.instr_i = ins;
    hz.pc_sel_i = ps;
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    drive(NOP, 2'b00);
    tick();
    rst = 1'b0;
    drive(NOP, 2'b00);
    checks++;
    if (ctl !== 4'b0000) begin failures++; $display("FAIL reset_ctl got=%b exp=0000", ctl); end
    checks++;
    if ({hz.bypA_sel_o, hz.bypB_sel_o} !== 4'b0000) begin failures++; $display("FAIL reset_byp got=%b exp=0000", {hz.bypA_sel_o, hz.bypB_sel_o}); end
  endtask
  task automatic test_load();
    drive(mk(2'b00, 3'b000, 5'd5, 5'd0, 5'd0), 2'b00);
    tick();
    checks++;
    if (ctl !== 4'b1110) begin failures++; $display("FAIL load_c1 got=%b exp=1110", ctl); end
    tick();
    checks++;
    if (ctl !== 4'b1111) begin failures++; $display("FAIL load_c2 got=%b exp=1111", ctl); end
    tick();
    checks++;
    if (ctl !== 4'b0000) begin failures++; $display("FAIL load_c3 got=%b exp=0000", ctl); end
    drive(NOP, 2'b00);
    tick();
    tick();
  endtask
  task automatic test_bypass();
    drive(mk(2'b10, 3'b001, 5'd3, 5'd2, 5'd1), 2'b00);
    checks++;
    if ({hz.bypA_sel_o, hz.bypB_sel_o} !== 4'b0000) begin failures++; $display("FAIL byp_clean got=%b exp=0000", {hz.bypA_sel_o, hz.bypB_sel_o}); end
    tick();
    drive(mk(2'b10, 3'b000, 5'd1, 5'd3, 5'd2), 2'b00);
    checks++;
    if (hz.bypA_sel_o !== 2'b01) begin failures++; $display("FAIL byp_d1 got=%b exp=01", hz.bypA_sel_o); end
    tick();
    drive(mk(2'b11, 3'b000, 5'd4, 5'd3, 5'd2), 2'b00);
    checks++;
    if ({hz.bypA_sel_o, hz.bypB_sel_o} !== 4'b1000) begin failures++; $display("FAIL byp_d2 got=%b exp=1000", {hz.bypA_sel_o, hz.bypB_sel_o}); end
    tick();
    drive(mk(2'b10, 3'b001, 5'd4, 5'd1, 5'd4), 2'b00);
    checks++;
    if ({hz.bypA_sel_o, hz.bypB_sel_o} !== 4'b1001) begin failures++; $display("FAIL byp_both got=%b exp=1001", {hz.bypA_sel_o, hz.bypB_sel_o}); end
    tick();
    drive(mk(2'b10, 3'b000, 5'd9, 5'd4, 5'd4), 2'b00);
    checks++;
    if ({hz.bypA_sel_o, hz.bypB_sel_o} !== 4'b0101) begin failures++; $display("FAIL byp_prio got=%b exp=0101", {hz.bypA_sel_o, hz.bypB_sel_o}); end
    drive(NOP, 2'b00);
    tick();
    tick();
  endtask
  task automatic test_jump();
    drive(mk(2'b01, 3'b000, 5'd0, 5'd0, 5'd0), 2'b00);
    checks++;
    if (ctl !== 4'b0000) begin failures++; $display("FAIL jmp_c0 got=%b exp=0000", ctl); end
    tick();
    drive(NOP, 2'b00);
    checks++;
    if (ctl !== 4'b0110) begin failures++; $display("FAIL jmp_c1 got=%b exp=0110", ctl); end
    tick();
    checks++;
    if (ctl !== 4'b0000) begin failures++; $display("FAIL jmp_c2 got=%b exp=0000", ctl); end
  endtask
  task automatic test_branch();
    drive(mk(2'b10, 3'b000, 5'd1, 5'd0, 5'd0), 2'b00);
    tick();
    drive(mk(2'b01, 3'b001, 5'd0, 5'd0, 5'd0), 2'b00);
    checks++;
    if (ctl !== 4'b0000) begin failures++; $display("FAIL bz_alone got=%b exp=0000", ctl); end
    tick();
    drive(mk(2'b10, 3'b000, 5'd3, 5'd1, 5'd2), 2'b00);
    checks++;
    if ({hz.bypA_sel_o, hz.bypB_sel_o} !== 4'b1000) begin failures++; $display("FAIL br_d2 got=%b exp=1000", {hz.bypA_sel_o, hz.bypB_sel_o}); end
    tick();
    drive(mk(2'b10, 3'b000, 5'd5, 5'd3, 5'd0), 2'b01);
    checks++;
    if (ctl !== 4'b0011) begin failures++; $display("FAIL br_flush got=%b exp=0011", ctl); end
    checks++;
    if (hz.bypA_sel_o !== 2'b01) begin failures++; $display("FAIL br_bypA got=%b exp=01", hz.bypA_sel_o); end
    tick();
    drive(mk(2'b10, 3'b000, 5'd6, 5'd3, 5'd5), 2'b00);
    checks++;
    if ({hz.bypA_sel_o, hz.bypB_sel_o} !== 4'b0000) begin failures++; $display("FAIL br_hist_clr got=%b exp=0000", {hz.bypA_sel_o, hz.bypB_sel_o}); end
    drive(mk(2'b00, 3'b000, 5'd7, 5'd0, 5'd0), 2'b01);
    tick();
    drive(NOP, 2'b10);
    checks++;
    if (ctl !== 4'b0000) begin failures++; $display("FAIL br_load_suppr got=%b exp=0000", ctl); end
    drive(NOP, 2'b00);
    tick();
    tick();
  endtask
  task automatic test_r0_store();
    drive(mk(2'b10, 3'b000, 5'd0, 5'd0, 5'd0), 2'b00);
    tick();
    drive(mk(2'b10, 3'b000, 5'd7, 5'd0, 5'd0), 2'b00);
    checks++;
    if ({hz.bypA_sel_o, hz.bypB_sel_o} !== 4'b0000) begin failures++; $display("FAIL r0_byp got=%b exp=0000", {hz.bypA_sel_o, hz.bypB_sel_o}); end
    tick();
    drive(mk(2'b00, 3'b010, 5'd9, 5'd0, 5'd0), 2'b00);
    tick();
    drive(mk(2'b10, 3'b001, 5'd1, 5'd9, 5'd9), 2'b00);
    checks++;
    if ({hz.bypA_sel_o, hz.bypB_sel_o} !== 4'b0000) begin failures++; $display("FAIL store_byp got=%b exp=0000", {hz.bypA_sel_o, hz.bypB_sel_o}); end
    drive(NOP, 2'b00);
    tick();
    tick();
  endtask
  task automatic test_reset_mid();
    drive(mk(2'b00, 3'b000, 5'd5, 5'd0, 5'd0), 2'b00);
    tick();
    checks++;
    if (ctl !== 4'b1110) begin failures++; $display("FAIL mid_ld1 got=%b exp=1110", ctl); end
    rst = 1'b1;
    drive(mk(2'b10, 3'b000, 5'd5, 5'd5, 5'd0), 2'b00);
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== 4'b0000) begin failures++; $display("FAIL mid_abort got=%b exp=0000", ctl); end
    checks++;
    if (hz.bypA_sel_o !== 2'b00) begin failures++; $display("FAIL mid_hist got=%b exp=00", hz.bypA_sel_o); end
    drive(NOP, 2'b00);
    tick();
  endtask
  task automatic test_back_to_back();
    drive(mk(2'b01, 3'b111, 5'd0, 5'd0, 5'd0), 2'b00);
    tick();
    checks++;
    if (ctl !== 4'b0110) begin failures++; $display("FAIL b2b_j1 got=%b exp=0110", ctl); end
    tick();
    checks++;
    if (ctl !== 4'b0000) begin failures++; $display("FAIL b2b_idle got=%b exp=0000", ctl); end
    tick();
    checks++;
    if (ctl !== 4'b0110) begin failures++; $display("FAIL b2b_j2 got=%b exp=0110", ctl); end
    drive(NOP, 2'b00);
    tick();
  endtask
  initial begin
    hz.instr_i = NOP;
    hz.pc_sel_i = 2'b00;
    test_reset();
    test_load();
    test_bypass();
    test_jump();
    test_branch();
    test_r0_store();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
